// File: rtl/fb_plot_engine_if.sv
// Plot-request handshake carrying one (x, y, data) pixel write into fb_plot_engine.
interface fb_plot_engine_if #(
   parameter int XW     = 10,
   parameter int YW     = 9,
   parameter int DATA_W = 1
);
   logic              plot_valid;
   logic              plot_ready;
   logic [XW-1:0]     plot_x;
   logic [YW-1:0]     plot_y;
   logic [DATA_W-1:0] plot_data;

   modport master (output plot_valid, plot_x, plot_y, plot_data, input plot_ready);
   modport slave  (input plot_valid, plot_x, plot_y, plot_data, output plot_ready);
endinterface

// File: rtl/fb_plot_engine.sv
// Queued pixel-plot / frame-clear engine driving the frame-buffer write port.
// Requests pass through a small FIFO; a clear sweeps every address to CLEAR_VAL.
module fb_plot_engine #(
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int DATA_W     = 1,
   parameter int FIFO_DEPTH = 8,
   parameter int CLEAR_VAL  = 0,
   localparam int XW = $clog2(WIDTH),
   localparam int YW = $clog2(HEIGHT),
   localparam int AW = $clog2(WIDTH*HEIGHT),
   localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              resetn,
   fb_plot_engine_if.slave   plot_if,
   input  logic              clear_req,
   output logic              fb_wen,
   output logic [AW-1:0]     fb_addr,
   output logic [DATA_W-1:0] fb_wdata,
   output logic              busy,
   output logic              clear_done,
   output logic [7:0]        oor_count,
   output logic [CW-1:0]     fifo_count
);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic {RUN, CLEAR} state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [YW-1:0]     y;
      logic [XW-1:0]     x;
   } entry_t;

   entry_t              mem_q [FIFO_DEPTH];
   state_e              state_q, state_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [AW-1:0]       ctr_q, ctr_d;
   logic                fb_wen_q, fb_wen_d;
   logic [AW-1:0]       fb_addr_q, fb_addr_d;
   logic [DATA_W-1:0]   fb_wdata_q, fb_wdata_d;
   logic                clear_done_q, clear_done_d;
   logic [7:0]          oor_q, oor_d;
   logic                push, pop, flush;
   entry_t              head;

   assign plot_if.plot_ready = (count_q != CW'(FIFO_DEPTH));
   assign push               = plot_if.plot_valid && plot_if.plot_ready;
   assign head               = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {plot_if.plot_data, plot_if.plot_y, plot_if.plot_x};
      end
   end

   // A clear in RUN drops queued entries but keeps one pushed on the same edge,
   // which is done by moving the read pointer onto the current write slot.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      ctr_d        = ctr_q;
      fb_wen_d     = 1'b0;
      fb_addr_d    = fb_addr_q;
      fb_wdata_d   = fb_wdata_q;
      clear_done_d = 1'b0;
      oor_d        = oor_q;
      pop          = 1'b0;
      flush        = 1'b0;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end

      case (state_q)
         RUN: begin
            if (clear_req) begin
               state_d  = CLEAR;
               ctr_d    = '0;
               flush    = 1'b1;
               rd_ptr_d = wr_ptr_q;
            end else if (count_q != '0) begin
               pop      = 1'b1;
               rd_ptr_d = rd_ptr_q + PW'(1);
               if (int'(head.x) < WIDTH && int'(head.y) < HEIGHT) begin
                  fb_wen_d   = 1'b1;
                  fb_addr_d  = AW'(int'(head.x) + WIDTH * int'(head.y));
                  fb_wdata_d = head.data;
               end else if (oor_q != 8'hFF) begin
                  oor_d = oor_q + 8'd1;
               end
            end
         end
         CLEAR: begin
            fb_wen_d   = 1'b1;
            fb_addr_d  = ctr_q;
            fb_wdata_d = DATA_W'(CLEAR_VAL);
            ctr_d      = ctr_q + AW'(1);
            if (ctr_q == AW'(WIDTH*HEIGHT - 1)) begin
               state_d      = RUN;
               ctr_d        = '0;
               clear_done_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase

      if (flush) begin
         count_d = CW'(push);
      end else begin
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= RUN;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         ctr_q        <= '0;
         fb_wen_q     <= 1'b0;
         fb_addr_q    <= '0;
         fb_wdata_q   <= '0;
         clear_done_q <= 1'b0;
         oor_q        <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         ctr_q        <= ctr_d;
         fb_wen_q     <= fb_wen_d;
         fb_addr_q    <= fb_addr_d;
         fb_wdata_q   <= fb_wdata_d;
         clear_done_q <= clear_done_d;
         oor_q        <= oor_d;
      end
   end

   assign fb_wen     = fb_wen_q;
   assign fb_addr    = fb_addr_q;
   assign fb_wdata   = fb_wdata_q;
   assign clear_done = clear_done_q;
   assign oor_count  = oor_q;
   assign fifo_count = count_q;
   assign busy       = (state_q == CLEAR) || (count_q != '0);
endmodule

// File: tb/tb_fb_plot_engine.sv
// Scoreboard bench for fb_plot_engine: stimulus queues expected writes, a
// negedge monitor pops and compares every frame-buffer write it sees.
module tb_fb_plot_engine;
   // Non-power-of-two screen so out-of-range coordinates fit in the port widths.
   localparam int WIDTH      = 6;
   localparam int HEIGHT     = 3;
   localparam int DATA_W     = 1;
   localparam int FIFO_DEPTH = 4;
   localparam int CLEAR_VAL  = 1;
   localparam int XW         = $clog2(WIDTH);
   localparam int YW         = $clog2(HEIGHT);
   localparam int AW         = $clog2(WIDTH*HEIGHT);
   localparam int CW         = $clog2(FIFO_DEPTH) + 1;
   localparam int NPIX       = WIDTH * HEIGHT;

   typedef struct {
      int addr;
      int data;
   } exp_t;

   logic              clk       = 1'b0;
   logic              resetn    = 1'b0;
   logic              clear_req = 1'b0;
   logic              fb_wen;
   logic [AW-1:0]     fb_addr;
   logic [DATA_W-1:0] fb_wdata;
   logic              busy;
   logic              clear_done;
   logic [7:0]        oor_count;
   logic [CW-1:0]     fifo_count;

   exp_t sb[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   int   done0;
   int   guard;

   fb_plot_engine_if #(.XW(XW), .YW(YW), .DATA_W(DATA_W)) pif ();

   fb_plot_engine #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_W(DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH), .CLEAR_VAL(CLEAR_VAL)
   ) dut (
      .clk(clk), .resetn(resetn), .plot_if(pif), .clear_req(clear_req),
      .fb_wen(fb_wen), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .busy(busy),
      .clear_done(clear_done), .oor_count(oor_count), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Every write the DUT makes must match the head of the scoreboard.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (resetn && fb_wen) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL extra_write: got write addr=%0d data=%0d, expected no write",
                     fb_addr, fb_wdata);
         end else begin
            e = sb.pop_front();
            check_output("wr_addr", int'(fb_addr), e.addr);
            check_output("wr_data", int'(fb_wdata), e.data);
         end
      end
      if (resetn && clear_done) begin
         done_cnt++;
         check_output("clear_done_on_last_write", fb_wen ? int'(fb_addr) : -1, NPIX - 1);
      end
   end

   task automatic expect_write(input int a, input int d);
      exp_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic expect_clear(input int upto);
      for (int i = 0; i < upto; i++) expect_write(i, CLEAR_VAL);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input int x, input int y, input int d);
      int g = 0;
      pif.plot_valid = 1'b1;
      pif.plot_x     = XW'(x);
      pif.plot_y     = YW'(y);
      pif.plot_data  = DATA_W'(d);
      while (!pif.plot_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g == 100) check_output("send_ready_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      pif.plot_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear_req = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      @(negedge clk);
      while ((busy || fb_wen) && g < 200) begin
         @(negedge clk);
         g++;
      end
      check_output({name, "_idle_reached"}, int'(g < 200), 1);
      check_output({name, "_sb_drained"}, sb.size(), 0);
   endtask

   // Single plot into an idle engine: write appears exactly one cycle after accept.
   task automatic timed_plot(input int x, input int y, input int d, input int a);
      expect_write(a, d);
      check_output("tp_ready", int'(pif.plot_ready), 1);
      send(x, y, d);
      check_output("tp_no_write_yet", int'(fb_wen), 0);
      check_output("tp_fifo_count", int'(fifo_count), 1);
      check_output("tp_busy", int'(busy), 1);
      @(negedge clk);
      check_output("tp_write_now", int'(fb_wen), 1);
      @(negedge clk);
      check_output("tp_write_single", int'(fb_wen), 0);
      check_output("tp_busy_fall", int'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      pif.plot_valid = 1'b0;
      pif.plot_x     = '0;
      pif.plot_y     = '0;
      pif.plot_data  = '0;
      repeat (3) @(negedge clk);
      check_output("rst_fb_wen", int'(fb_wen), 0);
      check_output("rst_fb_addr", int'(fb_addr), 0);
      check_output("rst_fb_wdata", int'(fb_wdata), 0);
      check_output("rst_busy", int'(busy), 0);
      check_output("rst_clear_done", int'(clear_done), 0);
      check_output("rst_oor", int'(oor_count), 0);
      check_output("rst_fifo_count", int'(fifo_count), 0);
      check_output("rst_ready", int'(pif.plot_ready), 1);
      resetn = 1'b1;
      @(negedge clk);

      // Single in-range plot: (3,2) -> 3 + 6*2 = 15.
      timed_plot(3, 2, 1, 15);

      // Clear sweep with five pushes queued behind it; the fifth must stall.
      done0 = done_cnt;
      expect_clear(NPIX);
      pulse_clear();
      check_output("t2_busy_clear", int'(busy), 1);
      expect_write(0, 0);  send(0, 0, 0);
      expect_write(5, 1);  send(5, 0, 1);
      expect_write(8, 0);  send(2, 1, 0);
      expect_write(16, 1); send(4, 2, 1);
      check_output("t2_ready_full", int'(pif.plot_ready), 0);
      check_output("t2_fifo_full", int'(fifo_count), 4);
      expect_write(13, 1); send(1, 2, 1);
      wait_idle("t2");
      check_output("t2_clear_done_once", done_cnt - done0, 1);

      // Out-of-range requests are dropped and counted, saturating at 255.
      send(6, 0, 1);
      send(0, 3, 1);
      expect_write(17, 0);
      send(5, 2, 0);
      wait_idle("t3");
      check_output("t3_oor_two", int'(oor_count), 2);
      for (int i = 0; i < 300; i++) send(i % 8, 3, 1);
      wait_idle("t3b");
      check_output("t3_oor_sat", int'(oor_count), 255);

      // A queued entry is flushed by clear; the push on the clear edge survives.
      done0 = done_cnt;
      expect_clear(NPIX);
      expect_write(7, 1);
      pif.plot_valid = 1'b1;
      pif.plot_x     = XW'(2);
      pif.plot_y     = YW'(2);
      pif.plot_data  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pif.plot_x = XW'(1);
      pif.plot_y = YW'(1);
      clear_req  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pif.plot_valid = 1'b0;
      clear_req      = 1'b0;
      check_output("t4_retained", int'(fifo_count), 1);
      repeat (5) @(negedge clk);
      pulse_clear();
      wait_idle("t4");
      check_output("t4_clear_done_once", done_cnt - done0, 1);

      // Async reset in the middle of a sweep.
      expect_clear(11);
      pulse_clear();
      guard = 0;
      while (!(fb_wen && int'(fb_addr) == 10) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_output("t5_reached_ctr10", int'(guard < 50), 1);
      #2 resetn = 1'b0;
      #1;
      check_output("t5_async_wen", int'(fb_wen), 0);
      check_output("t5_async_addr", int'(fb_addr), 0);
      check_output("t5_async_wdata", int'(fb_wdata), 0);
      check_output("t5_async_busy", int'(busy), 0);
      check_output("t5_async_oor", int'(oor_count), 0);
      check_output("t5_async_fifo", int'(fifo_count), 0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      check_output("t5_sb_consumed", sb.size(), 0);
      done0 = done_cnt;
      repeat (25) @(negedge clk);
      check_output("t5_no_clear_done", done_cnt - done0, 0);
      check_output("t5_idle_run", int'(busy), 0);
      timed_plot(0, 0, 1, 0);
      wait_idle("t5");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
